// File: rtl/dwt_lift_seq_ctrl.sv
// Multi-level sequencing controller for the DWT lifting datapath: level 0 consumes external
// samples, deeper levels replay coarse coefficients in place. Optional abort via DWT_CTRL_ABORT_EN.
module dwt_lift_seq_ctrl #(
    parameter int unsigned N      = 16,
    parameter int unsigned LEVELS = 3,
    parameter int unsigned AW     = $clog2(N),
    parameter int unsigned LW     = $clog2(LEVELS + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_in,
`ifdef DWT_CTRL_ABORT_EN
    input  logic          abort,
`endif
    output logic          ready_in,
    output logic          iseven,
    output logic          even_wr_en,
    output logic          even_rd_en,
    output logic          valid_detail_out,
    output logic          valid_coarse_out,
    output logic          coarse_wr_en,
    output logic [AW-1:0] coarse_wr_addr,
    output logic          coarse_rd_en,
    output logic [AW-1:0] coarse_rd_addr,
    output logic [LW-1:0] level,
    output logic          busy,
    output logic          done
);

    typedef enum logic [1:0] {StIdle, StExt, StInt, StDone} state_e;

    state_e        r_state;
    logic [LW-1:0] r_level;
    logic [AW-1:0] r_idx;
    logic [AW-1:0] r_rd_cnt;
    logic          r_rd_active;
    logic          r_pvalid;

    logic [AW-1:0] w_last;
    logic          w_last_level;
    logic          w_abort;
    logic          w_proc;
    logic          w_odd;
    logic          w_rd;

    always_comb begin
        w_last       = AW'((N >> r_level) - 1);
        w_last_level = (r_level == LW'(LEVELS - 1));
    end

`ifdef DWT_CTRL_ABORT_EN
    assign w_abort = abort && ((r_state == StExt) || (r_state == StInt));
`else
    assign w_abort = 1'b0;
`endif

    // ready_in must read 0 while rst is held even though the state already sits in IDLE.
    assign ready_in = !rst && !w_abort && ((r_state == StIdle) || (r_state == StExt));
    assign w_rd     = (r_state == StInt) && r_rd_active && !w_abort;
    assign w_proc   = !w_abort && ((ready_in && valid_in) || ((r_state == StInt) && r_pvalid));
    assign w_odd    = w_proc && r_idx[0];

    always_comb begin
        iseven           = w_proc && !r_idx[0];
        even_wr_en       = w_proc && !r_idx[0];
        even_rd_en       = w_odd;
        valid_detail_out = w_odd;
        valid_coarse_out = w_odd;
        coarse_wr_en     = w_odd;
        coarse_wr_addr   = w_odd ? (r_idx >> 1) : '0;
        coarse_rd_en     = w_rd;
        coarse_rd_addr   = w_rd ? r_rd_cnt : '0;
        level            = r_level;
        busy             = (r_state == StExt) || (r_state == StInt);
        done             = (r_state == StDone);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_level     <= '0;
            r_idx       <= '0;
            r_rd_cnt    <= '0;
            r_rd_active <= 1'b0;
            r_pvalid    <= 1'b0;
        end else if (w_abort) begin
            r_state     <= StIdle;
            r_level     <= '0;
            r_idx       <= '0;
            r_rd_cnt    <= '0;
            r_rd_active <= 1'b0;
            r_pvalid    <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle, StExt: begin
                    if (w_proc) begin
                        r_state <= StExt;
                        if (r_idx == w_last) begin
                            r_idx <= '0;
                            if (LEVELS == 1) begin
                                r_state <= StDone;
                            end else begin
                                r_state     <= StInt;
                                r_level     <= LW'(1);
                                r_rd_cnt    <= '0;
                                r_rd_active <= 1'b1;
                            end
                        end else begin
                            r_idx <= r_idx + AW'(1);
                        end
                    end
                end
                StInt: begin
                    r_pvalid <= w_rd;
                    if (w_rd) begin
                        if (r_rd_cnt == w_last) begin
                            r_rd_active <= 1'b0;
                            r_rd_cnt    <= '0;
                        end else begin
                            r_rd_cnt <= r_rd_cnt + AW'(1);
                        end
                    end
                    // Read counter is always one ahead of the process index, so in-place writes
                    // never overtake pending reads.
                    if (r_pvalid) begin
                        if (r_idx == w_last) begin
                            r_idx <= '0;
                            if (w_last_level) begin
                                r_state <= StDone;
                                r_level <= '0;
                            end else begin
                                r_level     <= r_level + LW'(1);
                                r_rd_cnt    <= '0;
                                r_rd_active <= 1'b1;
                            end
                        end else begin
                            r_idx <= r_idx + AW'(1);
                        end
                    end
                end
                StDone: begin
                    r_state  <= StIdle;
                    r_pvalid <= 1'b0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_dwt_lift_seq_ctrl.sv
// Scoreboard bench for dwt_lift_seq_ctrl: two instances (N=8 with LEVELS=3 and LEVELS=1).
// Exercises the abort input when DWT_CTRL_ABORT_EN is defined.
module tb_dwt_lift_seq_ctrl;

    localparam int unsigned N = 8;

    typedef logic [18:0] rec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       v3, rdy3, ise3, ewr3, erd3, vd3, vc3, cwr3, crd3, busy3, done3;
    logic [2:0] wa3, ra3;
    logic [1:0] lvl3;
    logic       v1, rdy1, ise1, ewr1, erd1, vd1, vc1, cwr1, crd1, busy1, done1;
    logic [2:0] wa1, ra1;
    logic [0:0] lvl1;
    logic       abort3;

    rec_t q3[$];
    rec_t q1[$];
    int   checks = 0;
    int   failures = 0;
    int   done_cnt3 = 0;
    int   done_cnt1 = 0;

    initial forever #5 clk = ~clk;

    dwt_lift_seq_ctrl #(.N(N), .LEVELS(3)) u_dut3 (
        .clk              (clk),
        .rst              (rst),
        .valid_in         (v3),
`ifdef DWT_CTRL_ABORT_EN
        .abort            (abort3),
`endif
        .ready_in         (rdy3),
        .iseven           (ise3),
        .even_wr_en       (ewr3),
        .even_rd_en       (erd3),
        .valid_detail_out (vd3),
        .valid_coarse_out (vc3),
        .coarse_wr_en     (cwr3),
        .coarse_wr_addr   (wa3),
        .coarse_rd_en     (crd3),
        .coarse_rd_addr   (ra3),
        .level            (lvl3),
        .busy             (busy3),
        .done             (done3)
    );

    dwt_lift_seq_ctrl #(.N(N), .LEVELS(1)) u_dut1 (
        .clk              (clk),
        .rst              (rst),
        .valid_in         (v1),
`ifdef DWT_CTRL_ABORT_EN
        .abort            (1'b0),
`endif
        .ready_in         (rdy1),
        .iseven           (ise1),
        .even_wr_en       (ewr1),
        .even_rd_en       (erd1),
        .valid_detail_out (vd1),
        .valid_coarse_out (vc1),
        .coarse_wr_en     (cwr1),
        .coarse_wr_addr   (wa1),
        .coarse_rd_en     (crd1),
        .coarse_rd_addr   (ra1),
        .level            (lvl1),
        .busy             (busy1),
        .done             (done1)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Record: {level, prev_cycle_event, iseven, ewr, erd, vdet, vcoarse, cwr, waddr, crd, raddr,
    // done, busy, ready}. Level is not compared on the done cycle.
    task automatic cmp_rec(input string name, input rec_t act, input rec_t exp);
        rec_t m;
        m = exp[2] ? 19'h1FFFF : 19'h7FFFF;
        checks++;
        if ((act & m) !== (exp & m)) begin
            failures++;
            $display("FAIL %s: got %05h required %05h", name, act & m, exp & m);
        end
    endtask

    function automatic rec_t mk(input int lvl, input bit prev, input bit proc, input int i,
                                input bit rd, input int r, input bit dn, input bit bsy,
                                input bit rdy);
        logic [1:0] l;
        logic [2:0] wa;
        logic [2:0] ra;
        bit         ev;
        bit         od;
        l  = 2'(lvl);
        ev = proc && (i % 2 == 0);
        od = proc && (i % 2 == 1);
        wa = od ? 3'(i / 2) : 3'd0;
        ra = rd ? 3'(r) : 3'd0;
        return {l, prev, ev, ev, od, od, od, od, wa, rd, ra, dn, bsy, rdy};
    endfunction

    // Expected per-cycle events for one frame, straight from the level/length rules.
    task automatic gen(input int levels, input bit first_prev, input bit gapped,
                       output rec_t exp_q[$]);
        int lk;
        exp_q = {};
        for (int i = 0; i < N; i++)
            exp_q.push_back(mk(0, (i == 0) ? first_prev : !gapped, 1'b1, i, 1'b0, 0, 1'b0,
                               i != 0, 1'b1));
        for (int k = 1; k < levels; k++) begin
            lk = N >> k;
            for (int t = 0; t <= lk; t++)
                exp_q.push_back(mk(k, 1'b1, t >= 1, t - 1, t < lk, t, 1'b0, 1'b1, 1'b0));
        end
        exp_q.push_back(mk(0, 1'b1, 1'b0, 0, 1'b0, 0, 1'b1, 1'b0, 1'b0));
    endtask

    initial begin
        bit   last;
        rec_t act;
        last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last = 1'b0;
            end else if (ewr3 | erd3 | ise3 | vd3 | vc3 | cwr3 | crd3 | done3) begin
                act = {lvl3, last, ise3, ewr3, erd3, vd3, vc3, cwr3, wa3, crd3, ra3, done3,
                       busy3, rdy3};
                if (q3.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb3_unexpected: got %05h required no event", act);
                end else begin
                    cmp_rec("sb3", act, q3.pop_front());
                end
                if (done3) done_cnt3++;
                last = 1'b1;
            end else begin
                last = 1'b0;
            end
        end
    end

    initial begin
        bit   last;
        rec_t act;
        last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                last = 1'b0;
            end else if (ewr1 | erd1 | ise1 | vd1 | vc1 | cwr1 | crd1 | done1) begin
                act = {1'b0, lvl1, last, ise1, ewr1, erd1, vd1, vc1, cwr1, wa1, crd1, ra1, done1,
                       busy1, rdy1};
                if (q1.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL sb1_unexpected: got %05h required no event", act);
                end else begin
                    cmp_rec("sb1", act, q1.pop_front());
                end
                if (done1) done_cnt1++;
                last = 1'b1;
            end else begin
                last = 1'b0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_done3(input int target);
        int k;
        k = 0;
        while (done_cnt3 < target && k < 100) begin
            cyc(1);
            k++;
        end
        chk("done3_count", done_cnt3, target);
    endtask

    task automatic wait_done1(input int target);
        int k;
        k = 0;
        while (done_cnt1 < target && k < 100) begin
            cyc(1);
            k++;
        end
        chk("done1_count", done_cnt1, target);
    endtask

    initial begin
        rec_t tmp[$];
        rst    = 1'b1;
        v3     = 1'b0;
        v1     = 1'b0;
        abort3 = 1'b0;
        cyc(2);
        chk("rst_ready3", int'(rdy3), 0);
        chk("rst_busy3", int'(busy3), 0);
        chk("rst_rd3", int'(crd3), 0);
        rst = 1'b0;
        #1;
        chk("idle_ready3", int'(rdy3), 1);
        chk("idle_ready1", int'(rdy1), 1);
        chk("idle_busy3", int'(busy3), 0);
        chk("idle_level3", int'(lvl3), 0);
        chk("idle_done3", int'(done3), 0);

        // Three-level frame, back-to-back samples.
        gen(3, 1'b0, 1'b0, tmp);
        foreach (tmp[k]) q3.push_back(tmp[k]);
        v3 = 1'b1;
        cyc(8);
        v3 = 1'b0;
        wait_done3(1);
        cyc(2);
        chk("q3_empty_f1", q3.size(), 0);

        // Single-level frame with one-cycle gaps.
        gen(1, 1'b0, 1'b1, tmp);
        foreach (tmp[k]) q1.push_back(tmp[k]);
        for (int i = 0; i < N; i++) begin
            v1 = 1'b1;
            cyc(1);
            v1 = 1'b0;
            cyc(1);
        end
        wait_done1(1);
        cyc(2);
        chk("q1_empty", q1.size(), 0);

        // valid_in held through INT, then a second frame right after done.
        gen(3, 1'b0, 1'b0, tmp);
        foreach (tmp[k]) q3.push_back(tmp[k]);
        gen(3, 1'b1, 1'b0, tmp);
        foreach (tmp[k]) q3.push_back(tmp[k]);
        v3 = 1'b1;
        wait_done3(2);
        cyc(8);
        v3 = 1'b0;
        wait_done3(3);
        cyc(2);
        chk("q3_empty_b2b", q3.size(), 0);

        // Reset during level 1, after its first two read cycles.
        gen(3, 1'b0, 1'b0, tmp);
        for (int k = 0; k < 10; k++) q3.push_back(tmp[k]);
        v3 = 1'b1;
        cyc(8);
        v3 = 1'b0;
        cyc(2);
        rst = 1'b1;
        #1;
        chk("midrst_rd", int'(crd3), 0);
        chk("midrst_busy", int'(busy3), 0);
        chk("midrst_level", int'(lvl3), 0);
        chk("midrst_ready", int'(rdy3), 0);
        chk("midrst_cwr", int'(cwr3 | ewr3 | erd3), 0);
        chk("midrst_q3", q3.size(), 0);
        cyc(1);
        rst = 1'b0;
        gen(3, 1'b0, 1'b0, tmp);
        foreach (tmp[k]) q3.push_back(tmp[k]);
        v3 = 1'b1;
        cyc(8);
        v3 = 1'b0;
        wait_done3(4);
        cyc(2);
        chk("q3_empty_after_rst", q3.size(), 0);

`ifdef DWT_CTRL_ABORT_EN
        gen(3, 1'b0, 1'b0, tmp);
        for (int k = 0; k < 5; k++) q3.push_back(tmp[k]);
        v3 = 1'b1;
        cyc(5);
        abort3 = 1'b1;
        #1;
        chk("abort_strobes", int'(ewr3 | erd3 | cwr3 | vd3), 0);
        cyc(1);
        abort3 = 1'b0;
        v3     = 1'b0;
        chk("abort_busy", int'(busy3), 0);
        chk("abort_ready", int'(rdy3), 1);
        chk("abort_level", int'(lvl3), 0);
        cyc(4);
        chk("abort_no_done", done_cnt3, 4);
        chk("abort_q3", q3.size(), 0);
`endif

        chk("final_done1", done_cnt1, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dwt_lift_seq_ctrl.md
# dwt_lift_seq_ctrl

Parametrised multi-level sequencing controller for the DWT lifting datapath. Counts samples internally, generates even/odd phase, even-register and coarse-buffer strobes and addresses, and iterates the lifting pass over `LEVELS` decomposition levels. Level 0 consumes external samples; levels 1..`LEVELS`-1 replay the coarse coefficients stored in place in the coarse buffer. Sits between the input stream and the predict/update datapath, replacing the fixed-length single-level controller.

## Interface
- `N`, 16: level-0 frame length; power of two, N >> (LEVELS-1) >= 2
- `LEVELS`, 3: decomposition levels, >= 1
- `AW`, $clog2(N): coarse buffer address width
- `LW`, $clog2(LEVELS+1): level index width
- `clk` in 1: clock, rising edge
- `rst` in 1: reset, asynchronous, active-high
- `valid_in` in 1: external sample strobe, accepted when `ready_in`=1
- `ready_in` out 1: 1 in IDLE/EXT, else 0
- `iseven` out 1: current processed sample has even index
- `even_wr_en` out 1: latch even sample into even register
- `even_rd_en` out 1: read even register (odd-sample cycle)
- `valid_detail_out` out 1: detail coefficient valid
- `valid_coarse_out` out 1: coarse coefficient valid
- `coarse_wr_en` out 1: write coarse coefficient to buffer
- `coarse_wr_addr` out AW: coarse write address
- `coarse_rd_en` out 1: read coarse buffer (levels >= 1)
- `coarse_rd_addr` out AW: coarse read address
- `level` out LW: level currently being processed
- `busy` out 1: frame in progress (EXT or INT)
- `done` out 1: one-cycle pulse, frame complete

## Operation
- States: IDLE, EXT, INT, DONE. Reset -> IDLE.
- Level length Lk = N >> k. Processing index i = 0..Lk-1 per level.
- A processed sample at index i: even i -> `iseven`=1, `even_wr_en`=1; odd i -> `iseven`=0, `even_rd_en`=1, `valid_detail_out`=1, `valid_coarse_out`=1, `coarse_wr_en`=1, `coarse_wr_addr`=i>>1. All other strobes 0.
- IDLE: accepted `valid_in` is sample i=0 of level 0; go to EXT.
- EXT: index advances only on accepted `valid_in`; gaps allowed, no strobes during gaps. After i=L0-1: LEVELS=1 -> DONE, else INT with `level`=1.
- INT: read counter r issues `coarse_rd_en`=1, `coarse_rd_addr`=r for r=0..Lk-1 on consecutive cycles; processed sample i=r occurs one cycle later (internal valid = registered `coarse_rd_en`). In-place safe: write addr j always < next read addr.
- After processing i=Lk-1: if level < LEVELS-1, level++ and reads restart next cycle; else DONE.
- DONE: `done`=1 for one cycle, -> IDLE. `valid_in` ignored outside IDLE/EXT.
- Detail outputs per frame: N/2 + N/4 + ... + Lk/2 over all levels.

## Timing
- All outputs 0 while `rst` high and after reset, except `ready_in`=1 once `rst` deasserts (IDLE).
- Level 0: strobes combinational from accepted `valid_in` and index; zero latency.
- Level >= 1: processing strobes 1 cycle after matching `coarse_rd_en`; one bubble cycle between levels (no read issued on the last-process cycle of a level).
- `level` updates on the cycle after the last processed sample of the previous level.
- `busy`=1 in EXT and INT; 0 in IDLE and DONE.
- `rst` mid-frame: immediate return to IDLE, counters cleared, no `done`.

## Configuration
- `DWT_CTRL_ABORT_EN` defined: adds input `abort` (1 bit). `abort`=1 in EXT/INT -> IDLE on next edge, counters cleared, all strobes 0 that cycle, no `done` pulse; ignored in IDLE/DONE.
- Undefined: no `abort` port; frame only terminates by completion or `rst`.

## Test plan
- N=8, LEVELS=3, 8 back-to-back `valid_in` -> level 0: 4 even/4 odd alternating, coarse writes addr 0..3; level 1 reads addr 0..3, writes 0..1; level 2 reads 0..1, writes 0; 7 `valid_detail_out` total; `done` once.
- N=8, LEVELS=1, `valid_in` with 1-cycle gaps -> strobes only on valid cycles, `done` 1 cycle after 8th sample, `coarse_rd_en` never asserted.
- `valid_in` held high during INT -> `ready_in`=0, no extra samples counted, sequence identical to first case.
- `rst` asserted during level 1 -> all outputs 0 immediately, `level`=0; next frame runs fully correct.
- Two frames back-to-back -> second frame's first `valid_in` accepted the cycle after `done`.
- With `DWT_CTRL_ABORT_EN`, `abort` at level-0 index 5 -> IDLE next cycle, no `done`, no further coarse writes.
